// File: rtl/vector_operand_collector.sv
// Vector operand collector: accepts one instruction's source specifiers,
// issues one to three in-order reads to the vector register file, gathers
// the returned rows (and the v0 mask when masked) and hands the bundle to
// the lanes.
//
// Handshake semantics (both the issue side and the lane side):
//   a transfer happens on a rising clock edge where valid && ready are both
//   high; valid never depends combinationally on ready on the producing side,
//   and once out_valid is raised the bundle is held stable until out_ready.
//   The read port uses rd_req/rd_gnt the same way: rd_idx is held while
//   rd_req && !rd_gnt, and responses (rd_rvalid) come back in request order.
module vector_operand_collector #(
    parameter int NUM_ELEMENTS = 32,
    parameter int ELEM_W       = 16,
    parameter int VREG_IDX_W   = 5,
    parameter int TAG_W        = 4
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [VREG_IDX_W-1:0]          in_vs1,
    input  logic [VREG_IDX_W-1:0]          in_vs2,
    input  logic                           in_use_vs2,
    input  logic                           in_vm,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           rd_req,
    output logic [VREG_IDX_W-1:0]          rd_idx,
    input  logic                           rd_gnt,
    input  logic                           rd_rvalid,
    input  logic [NUM_ELEMENTS*ELEM_W-1:0] rd_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ELEMENTS*ELEM_W-1:0] out_vs1,
    output logic [NUM_ELEMENTS*ELEM_W-1:0] out_vs2,
    output logic [NUM_ELEMENTS-1:0]        out_mask,
    output logic [TAG_W-1:0]               out_tag,
    output logic                           busy,
    output logic                           err_spurious,
    output logic [1:0]                     state_dbg
);

    localparam int ROW_W = NUM_ELEMENTS * ELEM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    // Destination of each entry in the read list.
    typedef enum logic [1:0] {
        SLOT_VS1  = 2'd0,
        SLOT_VS2  = 2'd1,
        SLOT_MASK = 2'd2
    } slot_t;

    state_t                state;
    state_t                state_next;

    // Latched read list: register index and destination per entry.
    logic [VREG_IDX_W-1:0] list_idx  [3];
    slot_t                 list_slot [3];
    logic [1:0]            list_len;
    logic                  dup;

    // Read list computed from the incoming request.
    logic [VREG_IDX_W-1:0] new_idx   [3];
    slot_t                 new_slot  [3];
    logic [1:0]            new_len;

    // issue_cnt counts grants, resp_cnt counts accepted responses.
    logic [1:0]            issue_cnt;
    logic [1:0]            resp_cnt;
    logic [1:0]            resp_cnt_next;

    logic                  accept;
    logic                  grant;
    logic                  resp_ok;
    logic                  spurious;
    logic                  last_grant;
    slot_t                 resp_slot;

    assign in_ready  = (state == IDLE) || ((state == VALID) && out_ready);
    assign accept    = in_valid && in_ready;
    assign rd_req    = (state == ISSUE);
    assign grant     = rd_req && rd_gnt;
    // A response is only legal while some granted read is still unanswered.
    assign resp_ok   = rd_rvalid && (resp_cnt < issue_cnt);
    assign spurious  = rd_rvalid && !resp_ok;
    assign resp_cnt_next = resp_cnt + {1'b0, resp_ok};
    assign last_grant    = grant && ((issue_cnt + 2'd1) == list_len);
    assign out_valid = (state == VALID);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Build the ordered read list: vs1, then a distinct vs2, then v0 for the mask.
    always_comb begin
        new_idx[0]  = in_vs1;
        new_slot[0] = SLOT_VS1;
        new_idx[1]  = '0;
        new_slot[1] = SLOT_MASK;
        new_idx[2]  = '0;
        new_slot[2] = SLOT_MASK;
        new_len     = 2'd1;
        if (in_use_vs2 && (in_vs2 != in_vs1)) begin
            new_idx[1]  = in_vs2;
            new_slot[1] = SLOT_VS2;
            new_len     = 2'd2;
            if (in_vm) begin
                new_idx[2]  = '0;
                new_slot[2] = SLOT_MASK;
                new_len     = 2'd3;
            end
        end else if (in_vm) begin
            new_idx[1]  = '0;
            new_slot[1] = SLOT_MASK;
            new_len     = 2'd2;
        end
    end

    // Select the register index for the read currently being requested.
    always_comb begin
        rd_idx = '0;
        case (issue_cnt)
            2'd0:    rd_idx = list_idx[0];
            2'd1:    rd_idx = list_idx[1];
            2'd2:    rd_idx = list_idx[2];
            default: rd_idx = '0;
        endcase
    end

    // Select the destination slot of the response being returned.
    always_comb begin
        resp_slot = SLOT_VS1;
        case (resp_cnt)
            2'd0:    resp_slot = list_slot[0];
            2'd1:    resp_slot = list_slot[1];
            2'd2:    resp_slot = list_slot[2];
            default: resp_slot = SLOT_VS1;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; VALID can hand straight back to ISSUE with no bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (last_grant) begin
                    state_next = (resp_cnt_next == list_len) ? VALID : WAIT;
                end
            end
            WAIT: begin
                if (resp_cnt_next == list_len) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_next = accept ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the read list and instruction attributes at accept.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 3; i++) begin
                list_idx[i]  <= '0;
                list_slot[i] <= SLOT_VS1;
            end
            list_len <= 2'd0;
            dup      <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                list_idx[i]  <= new_idx[i];
                list_slot[i] <= new_slot[i];
            end
            list_len <= new_len;
            dup      <= in_use_vs2 && (in_vs2 == in_vs1);
        end
    end

    // Grant and response counters; both restart at every accept.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issue_cnt <= 2'd0;
            resp_cnt  <= 2'd0;
        end else if (accept) begin
            issue_cnt <= 2'd0;
            resp_cnt  <= 2'd0;
        end else begin
            if (grant) begin
                issue_cnt <= issue_cnt + 2'd1;
            end
            resp_cnt <= resp_cnt_next;
        end
    end

    // Operand bundle: defaults applied at accept, rows written as they return.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_vs1  <= '0;
            out_vs2  <= '0;
            out_mask <= '0;
            out_tag  <= '0;
        end else if (accept) begin
            out_tag <= in_tag;
            if (!in_vm) begin
                out_mask <= '1;
            end
            if (!in_use_vs2) begin
                out_vs2 <= '0;
            end
        end else if (resp_ok) begin
            case (resp_slot)
                SLOT_VS1: begin
                    out_vs1 <= rd_rdata;
                    if (dup) begin
                        out_vs2 <= rd_rdata;
                    end
                end
                SLOT_VS2:  out_vs2  <= rd_rdata;
                SLOT_MASK: out_mask <= rd_rdata[NUM_ELEMENTS-1:0];
                default:   out_vs1  <= out_vs1;
            endcase
        end
    end

    // Sticky flag for a response with nothing outstanding; only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_spurious <= 1'b0;
        end else if (spurious) begin
            err_spurious <= 1'b1;
        end
    end

    // Keep the unused width constant referenced for readers of the bundle size.
    logic unused_row_w;
    assign unused_row_w = (ROW_W == 0);

endmodule
